// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared definitions for the ADC SPI master.
//   - ADC register addresses
//   - frame layout constants for the 16-bit {rw, addr[2:0], data[11:0]} frame
//   - FSM state encoding
//   - build_frame(): packs a request into a frame (reads carry a zero data field)
package adc_spi_pkg;

  localparam logic [2:0] ADC_ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADC_ADDR_DATA   = 3'd1;
  localparam logic [2:0] ADC_ADDR_STATUS = 3'd2;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned RW_BIT     = 15;
  localparam int unsigned ADDR_MSB   = 14;
  localparam int unsigned ADDR_LSB   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        rw,
    input logic [2:0]  addr,
    input logic [11:0] wdata
  );
    logic [FRAME_BITS-1:0] f;
    f                   = '0;
    f[RW_BIT]           = rw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[11:0]             = rw ? wdata : '0;
    return f;
  endfunction

endpackage

// File: rtl/adc_spi_sck_gen.sv
// adc_spi_sck_gen: SPI clock generator for the ADC SPI master.
// While en is high, sck toggles every SCK_DIV sys_clk cycles, starting low.
// While en is low, sck is held low and the half-period counter is cleared.
// Ports:
//   sys_clk   in   system clock
//   reset_    in   asynchronous active-low reset
//   en        in   run the clock (master is in its shift phase)
//   sck       out  SPI clock, idle low
//   rise_stb  out  high in the cycle whose closing edge drives sck high
//   fall_stb  out  high in the cycle whose closing edge drives sck low
module adc_spi_sck_gen #(
  parameter int unsigned SCK_DIV = 4
) (
  input  logic sys_clk,
  input  logic reset_,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] HP_LAST = 8'(SCK_DIV - 1);

  logic [7:0] hp_cnt;
  logic       hp_end;

  assign hp_end   = en && (hp_cnt == HP_LAST);
  assign rise_stb = hp_end && !sck;
  assign fall_stb = hp_end && sck;

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      hp_cnt <= '0;
      sck    <= 1'b0;
    end else if (!en) begin
      hp_cnt <= '0;
      sck    <= 1'b0;
    end else if (hp_end) begin
      hp_cnt <= '0;
      sck    <= ~sck;
    end else begin
      hp_cnt <= hp_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// adc_spi_master: host-side SPI mode-0 initiator for the ADC register port.
// A req in IDLE latches {rw, addr, wdata} into one 16-bit MSB-first frame;
// done pulses for one cycle at frame end and rdata holds the last 12 miso
// bits of the most recent read frame.
// Optional feature (macro ADC_SPI_MASTER_IRQ_POLL_EN): a rising edge of the
// synchronised irq input while idle issues an internal read of the DATA
// register; its completion also pulses sample_valid.
// Ports:
//   sys_clk, reset_       clock, asynchronous active-low reset
//   req, rw, addr, wdata  request handshake and payload (sampled when busy=0)
//   busy                  transaction in progress
//   done                  one-cycle completion pulse
//   rdata                 read data, held until the next read completes
//   cs, sck, mosi, miso   SPI pins (cs active-low, sck idle low)
//   sample_valid          irq-triggered read completed (feature only)
//   irq                   ADC interrupt (feature only)
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int unsigned SCK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic        sys_clk,
  input  logic        reset_,
  input  logic        req,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [11:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [11:0] rdata,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
  output logic        sample_valid,
`endif
  input  logic        irq
);

  // SETUP spends CS_SETUP+1 cycles so that done lands 1+CS_SETUP+32*SCK_DIV+CS_HOLD
  // cycles after accept. The IDLE cycle counts as the last cs-high gap cycle,
  // so GAP itself lasts CS_GAP-1 cycles and is skipped entirely for CS_GAP=1.
  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
  localparam logic [3:0] GAP_LAST   = (CS_GAP > 1) ? 4'(CS_GAP - 2) : 4'd0;
  localparam spi_state_e HOLD_NEXT  = (CS_GAP > 1) ? ST_GAP : ST_IDLE;

  spi_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic [11:0] rx_q, rx_d;
  logic [11:0] rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic        cs_q, cs_d;
  logic        done_q, done_d;
  logic        rise_stb, fall_stb;

`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
  logic irq_s1, irq_s2, irq_d, irq_rise;
  logic irq_frame_q, irq_frame_d;
  logic sv_q, sv_d;

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
      irq_d  <= 1'b0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
      irq_d  <= irq_s2;
    end
  end

  assign irq_rise     = irq_s2 & ~irq_d;
  assign sample_valid = sv_q;
`else
  logic unused_irq;
  assign unused_irq = irq;
`endif

  adc_spi_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .sys_clk  (sys_clk),
    .reset_   (reset_),
    .en       (state_q == ST_SHIFT),
    .sck      (sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;
  assign cs    = cs_q;
  assign mosi  = sh_q[15];

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
      irq_frame_q <= 1'b0;
      sv_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
      irq_frame_q <= irq_frame_d;
      sv_q        <= sv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
    irq_frame_d = irq_frame_q;
    sv_d        = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (req) begin
          sh_d    = build_frame(rw, addr, wdata);
          rw_d    = rw;
          cs_d    = 1'b0;
          state_d = ST_SETUP;
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
          irq_frame_d = 1'b0;
        end else if (irq_rise) begin
          sh_d        = build_frame(1'b0, ADC_ADDR_DATA, '0);
          rw_d        = 1'b0;
          cs_d        = 1'b0;
          state_d     = ST_SETUP;
          irq_frame_d = 1'b1;
`endif
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SHIFT: begin
        if (rise_stb) begin
          rx_d = {rx_q[10:0], miso};
        end
        if (fall_stb) begin
          sh_d  = {sh_q[14:0], 1'b0};
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            bit_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = HOLD_NEXT;
          if (!rw_q) begin
            rdata_d = rx_q;
          end
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
          sv_d = irq_frame_q;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// tb_adc_spi_master: randomized scoreboard bench for adc_spi_master with an
// SPI slave model that records mosi frames and returns a chosen 12-bit value.
module tb_adc_spi_master;

  localparam int P_DIV   = 2;
  localparam int P_SETUP = 1;
  localparam int P_HOLD  = 1;
  localparam int P_GAP   = 1;
  localparam int LAT     = 1 + P_SETUP + 32 * P_DIV + P_HOLD;

  typedef struct {
    logic [15:0] frame;
    logic [11:0] rdata;
    int          done_cyc;
    logic        from_irq;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset_;
  logic        req;
  logic        rw;
  logic [2:0]  addr;
  logic [11:0] wdata;
  logic        busy;
  logic        done;
  logic [11:0] rdata;
  logic        cs;
  logic        sck;
  logic        mosi;
  logic        miso = 1'b0;
  logic        irq;
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
  logic        sample_valid;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        new_e;
  logic [11:0] mdl_rdata = '0;
  logic [11:0] bfm_val   = '0;

  // slave model state
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;
  logic [15:0] bfm_tx = '0;
  logic [15:0] bfm_sh = '0;
  int          bfm_rises = 0;
  logic        mosi_at_rise = 1'b0;
  logic [15:0] last_frame = '0;
  int          last_rises = 0;
  int          sck_viol = 0;
  int          mosi_viol = 0;

`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_d = 1'b0, m_edge = 1'b0;
`endif

  adc_spi_master #(
    .SCK_DIV  (P_DIV),
    .CS_SETUP (P_SETUP),
    .CS_HOLD  (P_HOLD),
    .CS_GAP   (P_GAP)
  ) dut (
    .sys_clk      (sys_clk),
    .reset_       (reset_),
    .req          (req),
    .rw           (rw),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .cs           (cs),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso),
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
    .sample_valid (sample_valid),
`endif
    .irq          (irq)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Stimulus side of the scoreboard: a request is accepted on any edge where
  // req is high and no transaction is in flight; its response is predicted here.
  always @(posedge sys_clk) begin
    if (!reset_) begin
      exp_q.delete();
      mdl_rdata = '0;
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
      m_s1 = 1'b0; m_s2 = 1'b0; m_d = 1'b0;
`endif
    end else begin
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
      m_edge = m_s2 && !m_d;
      m_d    = m_s2;
      m_s2   = m_s1;
      m_s1   = irq;
`endif
      if (!busy && req) begin
        if (rw) begin
          new_e.frame = {1'b1, addr, wdata};
        end else begin
          new_e.frame = {1'b0, addr, 12'h000};
          mdl_rdata   = bfm_val;
        end
        new_e.rdata    = mdl_rdata;
        new_e.done_cyc = cyc + 1 + LAT;
        new_e.from_irq = 1'b0;
        exp_q.push_back(new_e);
      end
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
      else if (!busy && m_edge) begin
        new_e.frame    = 16'h1000;
        mdl_rdata      = bfm_val;
        new_e.rdata    = mdl_rdata;
        new_e.done_cyc = cyc + 1 + LAT;
        new_e.from_irq = 1'b1;
        exp_q.push_back(new_e);
      end
`endif
    end
  end

  // Slave model, protocol watch and scoreboard monitor share one block so the
  // frame captured at cs rise is ready when the coincident done is examined.
  always @(negedge sys_clk) begin
    if (prev_cs && !cs) begin
      bfm_tx    = {4'h0, bfm_val};
      miso      = bfm_tx[15];
      bfm_tx    = bfm_tx << 1;
      bfm_sh    = '0;
      bfm_rises = 0;
    end
    if (!cs && !prev_sck && sck) begin
      bfm_sh       = {bfm_sh[14:0], mosi};
      bfm_rises    = bfm_rises + 1;
      mosi_at_rise = mosi;
    end
    if (!cs && prev_sck && !sck) begin
      miso   = bfm_tx[15];
      bfm_tx = bfm_tx << 1;
    end
    if (!cs && sck && prev_sck && (mosi !== mosi_at_rise)) mosi_viol = mosi_viol + 1;
    if (cs && sck) sck_viol = sck_viol + 1;
    if (!prev_cs && cs) begin
      last_frame = bfm_sh;
      last_rises = bfm_rises;
    end
    prev_cs  = cs;
    prev_sck = sck;

    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency", cyc, mon_e.done_cyc);
        chk("rdata", rdata, mon_e.rdata);
        chk("frame", last_frame, mon_e.frame);
        chk("rises", last_rises, 16);
        chk("cs_at_done", cs, 1'b1);
        chk("sck_idle_low", sck_viol, 0);
        chk("mosi_stable", mosi_viol, 0);
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
        chk("sample_valid", sample_valid, mon_e.from_irq);
`endif
      end
      sck_viol  = 0;
      mosi_viol = 0;
    end
`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
    else if (sample_valid) begin
      chk("sample_valid_alone", sample_valid, 1'b0);
    end
`endif
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    if (busy !== 1'b0) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (done !== 1'b1 && k < 400);
    if (done !== 1'b1) chk("done_timeout", done, 1'b1);
  endtask

  task automatic do_frame(input logic f_rw, input logic [2:0] f_addr,
                          input logic [11:0] f_wdata, input logic [11:0] f_val);
    wait_idle();
    bfm_val = f_val;
    rw      = f_rw;
    addr    = f_addr;
    wdata   = f_wdata;
    req     = 1'b1;
    @(negedge sys_clk);
    req   = 1'b0;
    rw    = 1'($urandom);
    addr  = 3'($urandom);
    wdata = 12'($urandom);
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_high;
    int busy_low;
    int k;
    reset_ = 1'b0;
    req    = 1'b0;
    rw     = 1'b0;
    addr   = '0;
    wdata  = '0;
    irq    = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 12'h000);
    reset_ = 1'b1;
    @(negedge sys_clk);

    do_frame(1'b1, 3'd0, 12'h043, 12'h000);
    do_frame(1'b0, 3'd1, 12'hFFF, 12'hA5C);
    chk("rdata_after_read", rdata, 12'hA5C);

    for (int i = 0; i < 16; i++) begin
      do_frame(1'($urandom), 3'($urandom), 12'($urandom), 12'($urandom));
    end

    // req pulsed while busy must be dropped
    wait_idle();
    bfm_val = 12'h123;
    rw = 1'b0; addr = 3'd2; req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    repeat (10) @(negedge sys_clk);
    rw = 1'b1; addr = 3'd5; wdata = 12'hBEE; req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    wait_done();
    repeat (LAT + 10) @(negedge sys_clk);
    chk("busy_req_ignored", busy, 1'b0);
    chk("rdata_hold", rdata, 12'h123);

    // req held high: back-to-back frames
    wait_idle();
    bfm_val = 12'h6E1;
    rw = 1'b0; addr = 3'd3; req = 1'b1;
    wait_done();
    cs_high  = (cs === 1'b1) ? 1 : 0;
    busy_low = (busy === 1'b0) ? 1 : 0;
    k = 0;
    while (cs === 1'b1 && k < 20) begin
      @(negedge sys_clk);
      k++;
      if (cs === 1'b1) cs_high++;
      if (busy === 1'b0) busy_low++;
    end
    req = 1'b0;
    chk("b2b_cs_gap", cs_high, P_GAP);
    chk("b2b_busy_low", busy_low, 1);
    wait_done();

    // reset in the middle of a read
    wait_idle();
    bfm_val = 12'h777;
    rw = 1'b0; addr = 3'd1; req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    repeat (3) @(negedge sys_clk);
    k = 0;
    while (bfm_rises < 7 && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    if (bfm_rises < 7) chk("bit7_timeout", bfm_rises, 7);
    #2 reset_ = 1'b0;
    #1;
    chk("midrst_cs", cs, 1'b1);
    chk("midrst_sck", sck, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge sys_clk);
    chk("midrst_no_done", done, 1'b0);
    chk("midrst_rdata", rdata, 12'h000);
    reset_ = 1'b1;
    @(negedge sys_clk);
    do_frame(1'b0, 3'd1, 12'h0AA, 12'h5A3);
    chk("read_after_reset", rdata, 12'h5A3);

`ifdef ADC_SPI_MASTER_IRQ_POLL_EN
    wait_idle();
    bfm_val = 12'h3FF;
    irq = 1'b1;
    wait_done();
    chk("irq_rdata", rdata, 12'h3FF);
    irq = 1'b0;
    repeat (5) @(negedge sys_clk);
    wait_idle();
    bfm_val = 12'h0F0;
    rw = 1'b1; addr = 3'd2; wdata = 12'h9C3;
    irq = 1'b1;
    repeat (2) @(negedge sys_clk);
    req = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    wait_done();
    irq = 1'b0;
    repeat (LAT + 10) @(negedge sys_clk);
    chk("irq_dropped_busy", busy, 1'b0);
`endif

    repeat (5) @(negedge sys_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_master.md
Name: adc_spi_master

Overview:
- Host-side SPI initiator that drives the ADC block's SPI slave port (cs/sck/mosi/miso).
- Converts a parallel register-access request into one 16-bit SPI mode-0 frame and returns read data on a req/done handshake.
- Sits in the host/test subsystem, clocked by sys_clk; one instance per ADC.

Parameters:
- SCK_DIV, 4: sys_clk cycles per SCK half-period (legal range 1..255).
- CS_SETUP, 2: sys_clk cycles from cs low to the first SCK rising edge (legal range 1..15).
- CS_HOLD, 2: sys_clk cycles from the last SCK falling edge to cs high (legal range 1..15).
- CS_GAP, 2: minimum cs-high cycles between frames (legal range 1..15).

Ports:
- sys_clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- req  in  1  start transaction; sampled only when busy=0
- rw  in  1  1=write, 0=read; latched with req
- addr  in  3  register address; latched with req
- wdata  in  12  write data; latched with req
- busy  out  1  transaction in progress, including the gap
- done  out  1  one-cycle pulse at frame end
- rdata  out  12  read data; valid at done and held until the next done
- cs  out  1  SPI chip select, active-low
- sck  out  1  SPI clock, idle low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- irq  in  1  ADC interrupt; used only with IRQ_POLL_EN

Behaviour:
- Reset values:
  - cs=1, sck=0, mosi=0
  - busy=0, done=0, rdata=0
  - state=IDLE, all counters 0
- Frame format: 16 bits, MSB first, {rw, addr[2:0], wdata[11:0]}. For reads, the wdata field is sent as 0.
- SPI mode 0:
  - mosi is updated on sck falling edges; bit15 is driven when cs falls.
  - miso is sampled on sck rising edges, in the sys_clk cycle where sck goes high.
  - The last 12 sampled bits form rdata[11:0]. rdata updates only on read frames; write frames leave it unchanged.
- FSM states and transitions:
  - IDLE: on req=1, latch the frame into a 16-bit shift register; set busy=1 and cs=0 on the next edge; go to SETUP.
  - SETUP: count CS_SETUP cycles, then go to SHIFT.
  - SHIFT: half-period counter toggles sck every SCK_DIV cycles. Bit counter runs 0..15; after the 16th falling edge, go to HOLD. sck stays low.
  - HOLD: count CS_HOLD cycles. On the exit edge, set cs=1, pulse done=1, and update rdata if the frame was a read. Go to GAP.
  - GAP: count CS_GAP cycles, then clear busy and return to IDLE.
- Latency: done asserts exactly 1+CS_SETUP+32*SCK_DIV+CS_HOLD cycles after the req-accept edge.
- req while busy=1 is ignored and not queued. req held high across IDLE re-accepts immediately, giving back-to-back frames separated by CS_GAP.
- rw/addr/wdata are don't-care after the accept edge.
- Reset mid-frame: immediate return to reset values; cs goes high asynchronously; no done pulse.
- Counters saturate or wrap only at their defined terminal counts. No arithmetic overflow is possible within the legal parameter ranges.

Optional Feature:
- Macro: ADC_SPI_MASTER_IRQ_POLL_EN.
- With the macro defined:
  - In IDLE with req=0 and a rising edge of synchronised irq (2-flop sync), the master issues an internal read of addr=ADC_ADDR_DATA.
  - User req has priority when both occur in the same cycle; the irq edge is then dropped.
  - Completion pulses both done and an extra output sample_valid, for 1 cycle.
- Without the macro: the sample_valid port is absent, the irq input is unused, and there is no irq-related logic.

Decomposition:
- Package adc_spi_pkg holds:
  - register addresses: ADC_ADDR_CTRL=3'd0, ADC_ADDR_DATA=3'd1, ADC_ADDR_STATUS=3'd2
  - frame constants: FRAME_BITS=16, RW_BIT=15, ADDR_MSB=14, ADDR_LSB=12
  - FSM state encoding
- One sub-module is natural: adc_spi_sck_gen, the half-period counter producing sck, rise_stb and fall_stb.

Test Plan (SCK_DIV=2, CS_SETUP=1, CS_HOLD=1, CS_GAP=1, SPI slave BFM):
- Write: req, rw=1, addr=0, wdata=12'h043 -> BFM captures 16'h8043; done exactly 67 cycles after accept; rdata stays 0.
- Read: req, rw=0, addr=1; BFM returns 12'hA5C -> BFM sees 16'h1000; rdata=12'hA5C at done; cs high at done.
- Protocol checks: sck idle low while cs=1; mosi stable during every sck-high phase; exactly 16 rising edges per frame.
- req pulsed during busy -> ignored. req held high -> two frames with cs high exactly 1 cycle between them, and busy low for 1 cycle.
- reset_ low at bit 7 of a read -> cs=1, sck=0, busy=0 immediately; no done. Next read returns correct data.
- (IRQ_POLL_EN) irq rises while idle -> auto read of addr 1; sample_valid and done pulse; rdata=BFM value 12'h3FF. Simultaneous irq edge and user req -> user frame only.
